// File: rtl/rr_arb_mux.sv
// -----------------------------------------------------------------------------
// rr_arb_mux
//   N-input arbitrating multiplexer with one registered output stage.
//   Several valid/ready producers share one downstream consumer. Each cycle at
//   most one producer is granted, either round-robin (RR=1) or fixed priority
//   with the lowest index winning (RR=0). The granted word is captured into
//   the output register together with the index of the channel it came from.
//
// Ports
//   clk        : clock, rising-edge active
//   reset_n    : asynchronous active-low reset
//   in_valid   : [N]        per-channel request valid
//   in_data    : [N*WIDTH]  packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_ready   : [N]        per-channel accept, one-hot or zero
//   out_valid  : output register holds valid data
//   out_data   : [WIDTH]    registered selected data
//   out_sel    : [SELW]     index of the channel that supplied out_data
//   out_ready  : consumer accepts out_data this cycle
// -----------------------------------------------------------------------------
module rr_arb_mux #(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  parameter int RR    = 1,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  // Highest legal channel index; the pointer wraps by comparing against this
  // so a non-power-of-two N never produces an out-of-range index.
  localparam logic [SELW-1:0] LAST_IDX = SELW'(N - 1);

  // Advance a channel index by one with explicit wrap from N-1 to 0.
  function automatic logic [SELW-1:0] next_idx(input logic [SELW-1:0] idx);
    logic [SELW-1:0] nxt;
    if (idx == LAST_IDX) begin
      nxt = '0;
    end else begin
      nxt = idx + SELW'(1);
    end
    return nxt;
  endfunction

  // Round-robin pick: first requester at or above ptr, wrapping.
  // Returns {found, index}.
  function automatic logic [SELW:0] pick_rr(input logic [N-1:0]    req,
                                            input logic [SELW-1:0] ptr);
    logic [SELW-1:0] idx;
    logic [SELW-1:0] sel;
    logic            found;
    idx   = ptr;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end else begin
        found = found;
      end
      idx = next_idx(idx);
    end
    return {found, sel};
  endfunction

  // Fixed-priority pick: lowest-index requester. Returns {found, index}.
  function automatic logic [SELW:0] pick_low(input logic [N-1:0] req);
    logic [SELW-1:0] sel;
    logic            found;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[k]) begin
        found = 1'b1;
        sel   = SELW'(k);
      end else begin
        found = found;
      end
    end
    return {found, sel};
  endfunction

  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_data;
  logic [SELW-1:0]     r_out_sel;
  logic [SELW-1:0]     r_ptr;

  logic                w_load;
  logic [SELW:0]       w_pick;
  logic                w_gnt_vld;
  logic [SELW-1:0]     w_gnt_idx;
  logic [WIDTH-1:0]    w_gnt_data;
  logic [N-1:0]        w_in_ready;
  logic                w_xfer;

  // Arbitration, handshake and data select for the current cycle.
  always_comb begin
    w_load     = ~r_out_valid | out_ready;
    w_in_ready = '0;
    w_gnt_data = '0;

    if (RR != 0) begin
      w_pick = pick_rr(in_valid, r_ptr);
    end else begin
      w_pick = pick_low(in_valid);
    end
    w_gnt_vld = w_pick[SELW];
    w_gnt_idx = w_pick[SELW-1:0];

    // Data select depends only on the grant index, so in_data never reaches
    // in_ready combinationally.
    for (int i = 0; i < N; i++) begin
      if (w_gnt_idx == SELW'(i)) begin
        w_gnt_data = in_data[i*WIDTH +: WIDTH];
      end else begin
        w_gnt_data = w_gnt_data;
      end
    end

    // Gated by reset_n so no producer sees an accept while the block is held
    // in reset.
    if (reset_n && w_load && w_gnt_vld) begin
      w_in_ready[w_gnt_idx] = 1'b1;
    end else begin
      w_in_ready = '0;
    end

    w_xfer = |w_in_ready;
  end

  assign in_ready = w_in_ready;

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_xfer) begin
        // Load (possibly replacing a word being drained in the same cycle).
        r_out_valid <= 1'b1;
        r_out_data  <= w_gnt_data;
        r_out_sel   <= w_gnt_idx;
        if (RR != 0) begin
          r_ptr <= next_idx(w_gnt_idx);
        end else begin
          r_ptr <= '0;
        end
      end else if (out_ready) begin
        // Drain without refill; data and index keep their last values.
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_arb_mux.sv
// -----------------------------------------------------------------------------
// tb_rr_arb_mux
//   Self-checking bench for rr_arb_mux. Three instances: N=4 round-robin,
//   N=4 fixed priority and N=3 round-robin. A reference model predicts the
//   grant per cycle; accepted words are pushed to a scoreboard queue and
//   compared when they appear at the output register.
// -----------------------------------------------------------------------------
module tb_rr_arb_mux;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic [3:0]  v0, v1;
  logic [2:0]  v2;
  logic [31:0] d0, d1;
  logic [23:0] d2;
  logic        or0, or1, or2;

  logic [3:0]  r0, r1;
  logic [2:0]  r2;
  logic        ov0, ov1, ov2;
  logic [7:0]  od0, od1, od2;
  logic [1:0]  os0, os1, os2;

  rr_arb_mux #(.WIDTH(W), .N(4), .RR(1)) u_rr4 (
    .clk(clk), .reset_n(reset_n), .in_valid(v0), .in_data(d0), .in_ready(r0),
    .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(or0));

  rr_arb_mux #(.WIDTH(W), .N(4), .RR(0)) u_fp4 (
    .clk(clk), .reset_n(reset_n), .in_valid(v1), .in_data(d1), .in_ready(r1),
    .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(or1));

  rr_arb_mux #(.WIDTH(W), .N(3), .RR(1)) u_rr3 (
    .clk(clk), .reset_n(reset_n), .in_valid(v2), .in_data(d2), .in_ready(r2),
    .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(or2));

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] sb_q[$];
  int         m_ptr[3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nch(input int j);
    return (j == 2) ? 3 : 4;
  endfunction

  function automatic bit is_rr(input int j);
    return (j != 1);
  endfunction

  function automatic logic [7:0] data_byte(input int j, input int g);
    logic [31:0] d;
    d = (j == 0) ? d0 : (j == 1) ? d1 : {8'h00, d2};
    return d[g*8 +: 8];
  endfunction

  // Reference grant: modulo search from the model pointer.
  function automatic int model_grant(input int j, input logic [3:0] v);
    int n;
    int idx;
    n = nch(j);
    for (int k = 0; k < n; k++) begin
      idx = is_rr(j) ? (m_ptr[j] + k) % n : k;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Drive one cycle on instance j, check outputs, update model, step to next negedge.
  task automatic cycle(input int j, input logic [3:0] v, input logic ordy,
                       output logic [3:0] irdy, output logic [7:0] od, output logic [1:0] os);
    logic       ov;
    logic       mv;
    logic       load;
    logic [3:0] vm;
    logic [3:0] exp_rdy;
    logic [9:0] e;
    int         g;
    vm = (j == 2) ? (v & 4'b0111) : v;
    case (j)
      0: begin v0 = vm; or0 = ordy; end
      1: begin v1 = vm; or1 = ordy; end
      default: begin v2 = vm[2:0]; or2 = ordy; end
    endcase
    #1;
    case (j)
      0: begin ov = ov0; od = od0; os = os0; irdy = r0; end
      1: begin ov = ov1; od = od1; os = os1; irdy = r1; end
      default: begin ov = ov2; od = od2; os = os2; irdy = {1'b0, r2}; end
    endcase
    mv = (sb_q.size() != 0);
    check_eq("out_valid", {31'd0, ov}, {31'd0, mv});
    if (mv) begin
      e = sb_q[0];
      check_eq("out_sel", {30'd0, os}, {30'd0, e[9:8]});
      check_eq("out_data", {24'd0, od}, {24'd0, e[7:0]});
    end
    load    = !mv || ordy;
    g       = model_grant(j, vm);
    exp_rdy = (load && g >= 0) ? (4'b0001 << g) : 4'b0000;
    check_eq("in_ready", {28'd0, irdy}, {28'd0, exp_rdy});
    if (mv && ordy) void'(sb_q.pop_front());
    if (load && g >= 0) begin
      sb_q.push_back({2'(g), data_byte(j, g)});
      if (is_rr(j)) m_ptr[j] = (g + 1) % nch(j);
    end
    @(negedge clk);
  endtask

  task automatic drain(input int j);
    logic [3:0] irdy;
    logic [7:0] od;
    logic [1:0] os;
    cycle(j, 4'b0000, 1'b1, irdy, od, os);
    cycle(j, 4'b0000, 1'b1, irdy, od, os);
  endtask

  task automatic random_run(input int j, input int ncyc);
    logic [3:0] irdy;
    logic [7:0] od;
    logic [1:0] os;
    for (int c = 0; c < ncyc; c++) begin
      case (j)
        0: d0 = $urandom;
        1: d1 = $urandom;
        default: d2 = 24'($urandom);
      endcase
      cycle(j, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), irdy, od, os);
    end
    drain(j);
  endtask

  logic [3:0] irdy;
  logic [7:0] od;
  logic [1:0] os;
  logic [3:0] n3_seq [6];

  initial begin
    reset_n = 1'b0;
    v0 = 4'b1111; v1 = 4'b1111; v2 = 3'b111;
    or0 = 1'b1; or1 = 1'b1; or2 = 1'b1;
    d0 = 32'h13121110; d1 = 32'h13121110; d2 = 24'h121110;
    m_ptr[0] = 0; m_ptr[1] = 0; m_ptr[2] = 0;
    n3_seq[0] = 4'b0001; n3_seq[1] = 4'b0010; n3_seq[2] = 4'b0100;
    n3_seq[3] = 4'b0001; n3_seq[4] = 4'b0010; n3_seq[5] = 4'b0100;

    // Reset state, requests present but nothing accepted.
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_out_valid", {31'd0, ov0}, 32'd0);
    check_eq("rst_out_data",  {24'd0, od0}, 32'd0);
    check_eq("rst_out_sel",   {30'd0, os0}, 32'd0);
    check_eq("rst_in_ready",  {28'd0, r0},  32'd0);
    check_eq("rst_in_ready3", {29'd0, r2},  32'd0);
    v0 = 4'b0000; v1 = 4'b0000; v2 = 3'b000;
    @(negedge clk);
    reset_n = 1'b1;

    // Round-robin sequence 0,1,2,3,0 with no bubbles.
    for (int k = 0; k < 5; k++) begin
      cycle(0, 4'b1111, 1'b1, irdy, od, os);
      check_eq("rr_grant", {28'd0, irdy}, {28'd0, 4'b0001 << (k % 4)});
    end
    cycle(0, 4'b1111, 1'b1, irdy, od, os);      // grant 1, ptr -> 2
    check_eq("rr_grant1", {28'd0, irdy}, 32'h2);

    // Pointer skip: ptr=2 with only 0 and 1 requesting.
    cycle(0, 4'b0011, 1'b1, irdy, od, os);
    check_eq("skip_g0", {28'd0, irdy}, 32'h1);
    cycle(0, 4'b0011, 1'b1, irdy, od, os);
    check_eq("skip_g1", {28'd0, irdy}, 32'h2);

    // Backpressure: load channel 1 with 0xAB then stall five cycles.
    d0 = 32'h1312AB10;
    cycle(0, 4'b0010, 1'b1, irdy, od, os);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 4'b1111, 1'b0, irdy, od, os);
      check_eq("bp_in_ready", {28'd0, irdy}, 32'h0);
      check_eq("bp_out_data", {24'd0, od}, 32'hAB);
      check_eq("bp_out_sel",  {30'd0, os}, 32'h1);
    end
    cycle(0, 4'b1111, 1'b1, irdy, od, os);
    check_eq("bp_release_g2", {28'd0, irdy}, 32'h4);

    // Reset mid-stream with out_valid=1: outputs clear without a clock edge.
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'd0, ov0}, 32'd0);
    check_eq("mid_rst_data",  {24'd0, od0}, 32'd0);
    check_eq("mid_rst_sel",   {30'd0, os0}, 32'd0);
    check_eq("mid_rst_ready", {28'd0, r0},  32'd0);
    @(posedge clk);
    #1;
    check_eq("mid_rst_ready_held", {28'd0, r0}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    sb_q.delete();
    m_ptr[0] = 0; m_ptr[1] = 0; m_ptr[2] = 0;
    d0 = 32'h13121110;
    cycle(0, 4'b1111, 1'b1, irdy, od, os);
    check_eq("post_rst_ptr0", {28'd0, irdy}, 32'h1);
    drain(0);
    random_run(0, 150);

    // Fixed priority: channel 1 always beats channel 3.
    d1 = 32'h13121110;
    for (int k = 0; k < 4; k++) begin
      cycle(1, 4'b1010, 1'b1, irdy, od, os);
      check_eq("fp_grant1", {28'd0, irdy}, 32'h2);
    end
    drain(1);
    random_run(1, 80);

    // Non-power-of-two N=3: 0,1,2,0,1,2 and wrap from 2 to 0.
    d2 = 24'h121110;
    for (int k = 0; k < 6; k++) begin
      cycle(2, 4'b0111, 1'b1, irdy, od, os);
      check_eq("n3_grant", {28'd0, irdy}, {28'd0, n3_seq[k]});
      check_eq("n3_sel_range", {31'd0, (os < 2'd3)}, 32'd1);
    end
    drain(2);
    random_run(2, 80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-input registered arbitrating multiplexer with per-channel valid/ready handshakes.
- Generalises the fixed-arity combinational muxes to any channel count N. Adds round-robin or fixed-priority arbitration and one output register stage.
- Used wherever several producers share one downstream consumer, e.g. memory request merge or writeback port sharing.

Parameters:
- WIDTH, 64, data width per channel.
- N, 4, number of input channels; N >= 2.
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).
- SELW, $clog2(N), width of the channel index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  N  per-channel request valid.
- in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel accept; at most one bit set per cycle.
- out_valid  output  1  output register holds valid data.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SELW  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset: asynchronous on reset_n low.
  - out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0.
  - in_ready is all zeros while reset_n is low.
  - A transfer in progress when reset asserts is dropped; it is not replayed.
- Load enable: load = ~out_valid | out_ready.
  - in_ready is combinational from out_ready and in_valid; there is no combinational path from in_data.
- Grant:
  - RR=1: the first valid channel searching upward from ptr, wrapping from N-1 to 0.
  - RR=0: the lowest-index valid channel.
  - in_ready[g] = load & in_valid[g]; all other in_ready bits are 0.
- Transfer on input channel i: in_valid[i] & in_ready[i].
  - On the next edge: out_data <= channel i data, out_sel <= i, out_valid <= 1.
- Latency and throughput: 1 cycle from input transfer to out_valid. Sustained throughput is 1 transfer per cycle when out_ready is held high.
- Drain: out_valid & out_ready with no input transfer in the same cycle gives out_valid <= 0. out_data and out_sel hold their last values.
- Simultaneous drain and load in one cycle: the register is replaced with no bubble.
- Stall: out_valid & ~out_ready.
  - out_data, out_sel and out_valid are held stable.
  - All in_ready bits are 0.
- Pointer update (RR=1 only): on each input transfer, ptr <= (g == N-1) ? 0 : g+1.
  - ptr is unchanged when no transfer occurs.
  - With RR=0, ptr is unused and stays 0.
- Fairness (RR=1): with all N channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0,...
  - Every requesting channel is granted within N transfers.
- Source rule: once in_valid is asserted, the source holds it and its data stable until accepted. The block does not check this.
- Non-power-of-two N: pointer wrap uses explicit compare to N-1, never modulo of SELW bits.
  - out_sel never takes a value >= N.
- No in_valid set: no grant and no state change, apart from the drain described above.

Test Plan:
- Reset: assert reset_n=0 mid-stream with out_valid=1 -> out_valid, out_data, out_sel and ptr read 0 immediately, without waiting for a clock edge; in_ready=0 while reset is held.
- Round-robin, N=4, RR=1, all in_valid=1, data_i=0x10+i, out_ready=1 -> out_sel sequence 0,1,2,3,0; out_data 0x10,0x11,0x12,0x13,0x10 on consecutive cycles; no bubbles.
- Pointer skip: ptr=2, in_valid=4'b0011 -> grant channel 0, then ptr=1; the next cycle with in_valid=4'b0011 grants channel 1.
- Backpressure: fill the register with channel 1 data 0xAB, then hold out_ready=0 for 5 cycles with in_valid=4'b1111 -> in_ready=0, out_data=0xAB, out_sel=1 throughout. On release, the next grant is channel 2.
- Fixed priority, RR=0, in_valid=4'b1010 repeatedly, out_ready=1 -> out_sel always 1; channel 3 is starved, which is expected in this mode.
- Non-power-of-two, N=3, all channels valid -> out_sel 0,1,2,0,1; never 3; ptr wraps from 2 to 0.
